neo_pattern_sequencer: RTL and testbench
========================================

Name: neo_pattern_sequencer

Overview:
- Upstream frame source for the NeoPixel strand controller; replaces the hand-driven Task2 stimulus.
- Generates a "chasing dot" animation: one lit pixel, at a selectable channel mix and brightness, advancing one position per frame.
- Drives the controller's per-colour load interface, then its send command, then holds for a fixed frame period before building the next frame.

Parameters:
- NUM_PIXELS, 5, pixels in strand; legal range 1..8, sets the position wrap point.
- FRAME_CYCLES, 2_500_000, clock cycles from the send_it pulse to the end of the frame (50 ms at 50 MHz); minimum 1.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run the animation; sampled at frame boundaries.
- brightness  in  8  level applied to lit channels.
- hue_sel  in  2  channel mix: 0=G, 1=R, 2=B, 3=all three.
- ready_to_load  in  1  controller accepts a load_color this cycle.
- ready_to_send  in  1  controller accepts send_it this cycle.
- pixel_index  out  3  pixel being loaded.
- color_index  out  2  channel being loaded: 0=G, 1=R, 2=B (3 never driven).
- color_level  out  8  level for pixel_index/color_index.
- load_color  out  1  one-cycle load strobe.
- send_it  out  1  one-cycle send strobe.
- frame_done  out  1  one-cycle pulse at end of hold.
- position  out  3  current lit pixel.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, FSM goes to IDLE, frame timer is 0.
- All outputs are registered. pixel_index, color_index and color_level are stable in the cycle load_color is high.
- IDLE: when enable=1, clear the pixel and colour counters (p=0, c=0) -> LOAD.
- LOAD: on a cycle where ready_to_load=1, register a load_color pulse with p, c and the computed level -> GAP.
  - If ready_to_load=0, wait indefinitely. No strobe is issued and the counters hold.
- GAP: one mandatory idle cycle; load_color returns to 0. Then advance:
  - c=0->1->2. After c=2, set c=0 and p=p+1.
  - After p=NUM_PIXELS-1 with c=2 -> SEND; otherwise -> LOAD.
  - Exactly 3*NUM_PIXELS loads per frame, in pixel-major order, with no skips and no duplicates.
- SEND: on a cycle where ready_to_send=1, register a one-cycle send_it pulse, clear the timer -> HOLD.
- HOLD: timer counts up each cycle. frame_done pulses in the cycle exactly FRAME_CYCLES cycles after send_it. In that same cycle:
  - position advances: position==NUM_PIXELS-1 wraps to 0, else increments.
  - Next state is LOAD if enable=1, else IDLE.
- Timer width is $clog2(FRAME_CYCLES+1). No other counter can overflow.
- Level rule:
  - level = brightness if pixel==position and the channel is selected by hue_sel; otherwise 0.
  - hue_sel=3 selects G, R and B.
  - brightness=0 produces an all-dark frame; the frame is still loaded and sent.
- Inputs are sampled at frame boundaries:
  - enable dropping mid-frame does not abort the frame; loads, send and hold all complete, then the FSM goes to IDLE.
  - brightness and hue_sel changing mid-frame take effect on the next load issued (no frame snapshot).
- load_color and send_it are never high in the same cycle.
- reset asserted mid-operation discards the partial frame. After release the FSM restarts from IDLE with position 0.

Optional Feature:
- Macro NEO_TRAIL_EN.
- Defined: the pixel immediately behind the dot, (position-1) modulo NUM_PIXELS, gets level brightness>>2 on the selected channels. If NUM_PIXELS=1 the trail pixel equals the dot and the dot level wins.
- Undefined: only the dot pixel is lit.
- Load count, ordering and timing are identical in both builds.

Decomposition:
- Package neo_pkg holds:
  - color_t enum: COLOR_G=2'd0, COLOR_R=2'd1, COLOR_B=2'd2.
  - seq_state_t enum: IDLE, LOAD, GAP, SEND, HOLD.
  - hue_sel encodings.
  - PIX_IDX_W=3 and LEVEL_W=8.
- Sub-module neo_frame_timer:
  - Parameterised by FRAME_CYCLES; clear and count-enable inputs.
  - Registered one-cycle done pulse.
  - Reused later for the strand controller's reset-latch timing.

Test Plan (NUM_PIXELS=5, FRAME_CYCLES=10):
- Reset asserted with random inputs -> all outputs 0. Release with enable=0 -> outputs stay 0 for 50 cycles.
- enable=1, brightness=8'hFF, hue_sel=1, ready_to_load=ready_to_send=1 -> expect:
  - 15 load_color pulses, each followed by at least one gap cycle.
  - Only (pixel 0, colour 1) carries 8'hFF; all others 8'h00.
  - Then exactly one send_it.
- ready_to_load held 0 for 20 cycles after the 7th load -> no strobes during the stall; the 8th load is pixel 2, colour 1; the total stays 15.
- Run 6 frames -> frame_done arrives 10 cycles after each send_it; position sequence is 0,1,2,3,4,0.
- hue_sel=3, brightness=8'h40, enable dropped after the 3rd load -> lit pixel has G=R=B=8'h40; the frame completes with send_it and frame_done, then IDLE with no further loads.
- reset asserted during GAP of the 5th load -> immediate all-zero outputs; after release and enable=1 the first load is pixel 0, colour 0. With NEO_TRAIL_EN at position=2, brightness=8'hFF, hue_sel=0 -> pixel 1 colour 0 = 8'h3F.

Source files
------------

// File: rtl/neo_pattern_sequencer_pkg.sv
// neo_pkg: shared types and constants for the NeoPixel pattern sequencer.
//
// Contents:
//   color_t      - channel index as used on the controller load interface
//   seq_state_t  - frame builder FSM states
//   HUE_*        - hue_sel encodings (G, R, B, all three)
//   PIX_IDX_W    - pixel index width (strands of up to 8 pixels)
//   LEVEL_W      - per-channel intensity width
//   channelSelected() - true when a channel is part of the selected mix
package neo_pkg;

    localparam int PIX_IDX_W = 3;
    localparam int LEVEL_W   = 8;

    typedef enum logic [1:0] {
        COLOR_G = 2'd0,
        COLOR_R = 2'd1,
        COLOR_B = 2'd2
    } color_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        SEND,
        HOLD
    } seq_state_t;

    localparam logic [1:0] HUE_G   = 2'd0;
    localparam logic [1:0] HUE_R   = 2'd1;
    localparam logic [1:0] HUE_B   = 2'd2;
    localparam logic [1:0] HUE_ALL = 2'd3;

    // Decide whether a channel carries light under the current hue mix.
    function automatic logic channelSelected(input logic [1:0] hueSel, input color_t color);
        logic sel;
        sel = 1'b0;
        case (hueSel)
            HUE_G:   sel = (color == COLOR_G);
            HUE_R:   sel = (color == COLOR_R);
            HUE_B:   sel = (color == COLOR_B);
            HUE_ALL: sel = 1'b1;
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/neo_frame_timer.sv
// neo_frame_timer: counts clock cycles after a clear and flags the cycle that
// lies exactly FRAME_CYCLES cycles after the clear cycle.
//
// Ports:
//   clock      - system clock
//   reset      - asynchronous, active-low reset
//   clear_i    - restart the count from zero (takes priority over counting)
//   count_en_i - advance the count this cycle
//   last_o     - combinational: the count sits on its final step (FRAME_CYCLES-1)
//   done_o     - registered one-cycle pulse, FRAME_CYCLES cycles after the clear cycle
//
// The count saturates at FRAME_CYCLES, so it can never wrap.
module neo_frame_timer #(
    parameter int FRAME_CYCLES = 2_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic last_o,
    output logic done_o
);

    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(FRAME_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    assign last_o = (count_q == LAST_CNT);

    // Next count and next done pulse; the pulse is registered so that it lands
    // in the same cycle the count reaches FRAME_CYCLES.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            done_d = last_o;
            if (count_q != MAX_CNT) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Count and pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/neo_pattern_sequencer.sv
// neo_pattern_sequencer: chasing-dot frame source for the NeoPixel strand controller.
//
// Each frame loads every channel of every pixel (pixel-major, G/R/B order) through
// the controller's load interface, issues one send command, then holds for
// FRAME_CYCLES cycles. The lit pixel advances one position per frame.
//
// Ports:
//   clock, reset   - system clock, asynchronous active-low reset
//   enable         - run the animation (checked at frame boundaries)
//   brightness     - level applied to lit channels
//   hue_sel        - channel mix: 0=G, 1=R, 2=B, 3=all
//   ready_to_load  - controller accepts load_color this cycle
//   ready_to_send  - controller accepts send_it this cycle
//   pixel_index, color_index, color_level - load payload, valid with load_color
//   load_color     - one-cycle load strobe
//   send_it        - one-cycle send strobe
//   frame_done     - one-cycle pulse at the end of the hold period
//   position       - current lit pixel
//
// Build option: define NEO_TRAIL_EN to light the pixel behind the dot at a quarter
// of the brightness on the selected channels.
module neo_pattern_sequencer
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS   = 5,
    parameter int FRAME_CYCLES = 2_500_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [LEVEL_W-1:0]   brightness,
    input  logic [1:0]           hue_sel,
    input  logic                 ready_to_load,
    input  logic                 ready_to_send,
    output logic [PIX_IDX_W-1:0] pixel_index,
    output logic [1:0]           color_index,
    output logic [LEVEL_W-1:0]   color_level,
    output logic                 load_color,
    output logic                 send_it,
    output logic                 frame_done,
    output logic [PIX_IDX_W-1:0] position
);

    localparam logic [PIX_IDX_W-1:0] LAST_PIX = PIX_IDX_W'(NUM_PIXELS - 1);

    seq_state_t           state_q, state_d;
    logic [PIX_IDX_W-1:0] pixCnt_q, pixCnt_d;
    color_t               colorCnt_q, colorCnt_d;
    logic [PIX_IDX_W-1:0] position_q, position_d;
    logic [PIX_IDX_W-1:0] pixelIndex_q, pixelIndex_d;
    logic [1:0]           colorIndex_q, colorIndex_d;
    logic [LEVEL_W-1:0]   colorLevel_q, colorLevel_d;
    logic                 loadColor_q, loadColor_d;
    logic                 sendIt_q, sendIt_d;
    logic [LEVEL_W-1:0]   level;
    logic                 timerClear;
    logic                 timerCountEn;
    logic                 timerLast;
    logic                 timerDone;

    // The timer restarts on the accepted send and runs for the whole hold state.
    assign timerClear   = (state_q == SEND) && ready_to_send;
    assign timerCountEn = (state_q == HOLD);

    neo_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (timerClear),
        .count_en_i(timerCountEn),
        .last_o    (timerLast),
        .done_o    (timerDone)
    );

`ifdef NEO_TRAIL_EN
    logic [PIX_IDX_W-1:0] trailPix;

    // Level for the channel about to be loaded. The trail pixel is checked after
    // the dot so that with a single pixel the dot level wins.
    always_comb begin
        trailPix = (position_q == '0) ? LAST_PIX : position_q - PIX_IDX_W'(1);
        level    = '0;
        if (channelSelected(hue_sel, colorCnt_q)) begin
            if (pixCnt_q == position_q) begin
                level = brightness;
            end else if (pixCnt_q == trailPix) begin
                level = brightness >> 2;
            end
        end
    end
`else
    // Level for the channel about to be loaded: only the dot pixel is lit.
    always_comb begin
        level = '0;
        if (channelSelected(hue_sel, colorCnt_q) && (pixCnt_q == position_q)) begin
            level = brightness;
        end
    end
`endif

    // Frame builder: walks pixel/channel counters through LOAD/GAP pairs, then
    // sends and holds. Brightness and hue are read live at each load, while
    // enable only matters in IDLE and at the end of the hold.
    always_comb begin
        state_d      = state_q;
        pixCnt_d     = pixCnt_q;
        colorCnt_d   = colorCnt_q;
        position_d   = position_q;
        pixelIndex_d = pixelIndex_q;
        colorIndex_d = colorIndex_q;
        colorLevel_d = colorLevel_q;
        loadColor_d  = 1'b0;
        sendIt_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    pixCnt_d   = '0;
                    colorCnt_d = COLOR_G;
                    state_d    = LOAD;
                end
            end

            LOAD: begin
                if (ready_to_load) begin
                    loadColor_d  = 1'b1;
                    pixelIndex_d = pixCnt_q;
                    colorIndex_d = colorCnt_q;
                    colorLevel_d = level;
                    state_d      = GAP;
                end
            end

            GAP: begin
                if (colorCnt_q == COLOR_B) begin
                    colorCnt_d = COLOR_G;
                    if (pixCnt_q == LAST_PIX) begin
                        pixCnt_d = '0;
                        state_d  = SEND;
                    end else begin
                        pixCnt_d = pixCnt_q + PIX_IDX_W'(1);
                        state_d  = LOAD;
                    end
                end else begin
                    colorCnt_d = (colorCnt_q == COLOR_G) ? COLOR_R : COLOR_B;
                    state_d    = LOAD;
                end
            end

            SEND: begin
                if (ready_to_send) begin
                    sendIt_d = 1'b1;
                    state_d  = HOLD;
                end
            end

            HOLD: begin
                // Leaving on the timer's final step makes the new position and
                // next state appear in the same cycle as frame_done.
                if (timerLast) begin
                    position_d = (position_q == LAST_PIX) ? '0 : position_q + PIX_IDX_W'(1);
                    pixCnt_d   = '0;
                    colorCnt_d = COLOR_G;
                    state_d    = enable ? LOAD : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pixCnt_q     <= '0;
            colorCnt_q   <= COLOR_G;
            position_q   <= '0;
            pixelIndex_q <= '0;
            colorIndex_q <= '0;
            colorLevel_q <= '0;
            loadColor_q  <= 1'b0;
            sendIt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pixCnt_q     <= pixCnt_d;
            colorCnt_q   <= colorCnt_d;
            position_q   <= position_d;
            pixelIndex_q <= pixelIndex_d;
            colorIndex_q <= colorIndex_d;
            colorLevel_q <= colorLevel_d;
            loadColor_q  <= loadColor_d;
            sendIt_q     <= sendIt_d;
        end
    end

    assign pixel_index = pixelIndex_q;
    assign color_index = colorIndex_q;
    assign color_level = colorLevel_q;
    assign load_color  = loadColor_q;
    assign send_it     = sendIt_q;
    assign frame_done  = timerDone;
    assign position    = position_q;

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// tb_neo_pattern_sequencer: directed bench for the chasing-dot sequencer with
// NUM_PIXELS=5 and FRAME_CYCLES=10. A table of frames gives the inputs and the
// hand-computed levels for the dot and trail pixels; hand-written sequences
// cover power-on reset, the post-frame idle and a reset mid-frame.
module tb_neo_pattern_sequencer;

    localparam int NUM_PIXELS   = 5;
    localparam int FRAME_CYCLES = 10;
    localparam int LOADS        = 3 * NUM_PIXELS;
    localparam int BUDGET       = 400;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] brightness;
    logic [1:0] hue_sel;
    logic       ready_to_load;
    logic       ready_to_send;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       frame_done;
    logic [2:0] position;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] bright;
        logic [1:0] hue;
        int         pos;
        logic [7:0] dotLvl [3];
        logic [7:0] trailLvl [3];
        int         stallAfter;
        int         stallLen;
        int         dropEnAfter;
    } frameVec_t;

    frameVec_t frames [6];

    neo_pattern_sequencer #(
        .NUM_PIXELS  (NUM_PIXELS),
        .FRAME_CYCLES(FRAME_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .brightness   (brightness),
        .hue_sel      (hue_sel),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .pixel_index  (pixel_index),
        .color_index  (color_index),
        .color_level  (color_level),
        .load_color   (load_color),
        .send_it      (send_it),
        .frame_done   (frame_done),
        .position     (position)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic frameVec_t mkVec(
        input logic [7:0] bright, input logic [1:0] hue, input int pos,
        input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
        input logic [7:0] tg, input logic [7:0] tr, input logic [7:0] tb,
        input int stallAfter, input int stallLen, input int dropEnAfter);
        frameVec_t v;
        v.bright      = bright;
        v.hue         = hue;
        v.pos         = pos;
        v.dotLvl[0]   = g;
        v.dotLvl[1]   = r;
        v.dotLvl[2]   = b;
        v.trailLvl[0] = tg;
        v.trailLvl[1] = tr;
        v.trailLvl[2] = tb;
        v.stallAfter  = stallAfter;
        v.stallLen    = stallLen;
        v.dropEnAfter = dropEnAfter;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] br, input logic [1:0] hue,
                                 input logic rtl, input logic rts);
        enable        = en;
        brightness    = br;
        hue_sel       = hue;
        ready_to_load = rtl;
        ready_to_send = rts;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pixel_index"}, 32'(pixel_index), 0);
        checkOutput({tag, "_color_index"}, 32'(color_index), 0);
        checkOutput({tag, "_color_level"}, 32'(color_level), 0);
        checkOutput({tag, "_load_color"},  32'(load_color), 0);
        checkOutput({tag, "_send_it"},     32'(send_it), 0);
        checkOutput({tag, "_frame_done"},  32'(frame_done), 0);
        checkOutput({tag, "_position"},    32'(position), 0);
    endtask

    // Run one frame from the current negedge up to and including frame_done.
    task automatic runFrame(input frameVec_t v);
        int         loads;
        int         sends;
        int         cyc;
        int         sendCyc;
        int         expPix;
        int         expCol;
        int         trailPos;
        logic       prevLoad;
        logic       gotDone;
        logic       quiet;
        logic [7:0] expLvl;

        loads    = 0;
        sends    = 0;
        cyc      = 0;
        sendCyc  = 0;
        prevLoad = 1'b0;
        gotDone  = 1'b0;
        trailPos = (v.pos + NUM_PIXELS - 1) % NUM_PIXELS;
        applyStimulus(1'b1, v.bright, v.hue, 1'b1, 1'b1);

        while (!gotDone && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
            if (load_color) begin
                loads++;
                expPix = (loads - 1) / 3;
                expCol = (loads - 1) % 3;
                expLvl = 8'h00;
                if (expPix == v.pos) begin
                    expLvl = v.dotLvl[expCol];
                end
`ifdef NEO_TRAIL_EN
                else if (expPix == trailPos) begin
                    expLvl = v.trailLvl[expCol];
                end
`endif
                checkOutput("load_gap", 32'(prevLoad), 0);
                checkOutput("load_pixel", 32'(pixel_index), 32'(expPix));
                checkOutput("load_color_idx", 32'(color_index), 32'(expCol));
                checkOutput("load_level", 32'(color_level), 32'(expLvl));
                checkOutput("load_no_send", 32'(send_it), 0);
                if (loads == 1) begin
                    checkOutput("position_in_frame", 32'(position), 32'(v.pos));
                end
                if (loads == v.dropEnAfter) begin
                    enable = 1'b0;
                end
                if (loads == v.stallAfter) begin
                    ready_to_load = 1'b0;
                    quiet = 1'b1;
                    for (int k = 0; k < v.stallLen; k++) begin
                        @(negedge clock);
                        cyc++;
                        if (load_color || send_it) quiet = 1'b0;
                    end
                    checkOutput("stall_quiet", 32'(quiet), 1);
                    ready_to_load = 1'b1;
                    prevLoad = load_color;
                    continue;
                end
            end
            if (send_it) begin
                sends++;
                sendCyc = cyc;
                checkOutput("loads_at_send", 32'(loads), 32'(LOADS));
            end
            if (frame_done) begin
                gotDone = 1'b1;
                checkOutput("done_delay", 32'(cyc - sendCyc), 32'(FRAME_CYCLES));
                checkOutput("position_next", 32'(position), 32'((v.pos + 1) % NUM_PIXELS));
                checkOutput("send_count", 32'(sends), 1);
                checkOutput("load_count", 32'(loads), 32'(LOADS));
            end
            prevLoad = load_color;
        end
        checkOutput("frame_done_seen", 32'(gotDone), 1);
    endtask

    initial begin
        logic quiet;
        logic seen;
        int   loads;

        frames[0] = mkVec(8'hFF, 2'd1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h3F, 8'h00, 0, 0, 0);
        frames[1] = mkVec(8'hFF, 2'd1, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h3F, 8'h00, 7, 20, 0);
        frames[2] = mkVec(8'hFF, 2'd0, 2, 8'hFF, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 0, 0, 0);
        frames[3] = mkVec(8'h80, 2'd2, 3, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h20, 0, 0, 0);
        frames[4] = mkVec(8'h00, 2'd3, 4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        frames[5] = mkVec(8'h40, 2'd3, 0, 8'h40, 8'h40, 8'h40, 8'h10, 8'h10, 8'h10, 0, 0, 3);

        // Power-on reset with arbitrary inputs.
        reset = 1'b0;
        applyStimulus(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        repeat (4) @(negedge clock);
        checkAllZero("reset");

        // Release with enable low: nothing may move for 50 cycles.
        applyStimulus(1'b0, 8'hFF, 2'd1, 1'b1, 1'b1);
        reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (load_color || send_it || frame_done || (position != 3'd0) ||
                (pixel_index != 3'd0) || (color_index != 2'd0) || (color_level != 8'd0)) begin
                quiet = 1'b0;
            end
        end
        checkOutput("idle_quiet", 32'(quiet), 1);

        // Six table frames: position walks 0,1,2,3,4,0; the last drops enable.
        for (int f = 0; f < 6; f++) begin
            runFrame(frames[f]);
        end

        // Enable was dropped during the last frame, so the FSM must sit in IDLE.
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (load_color || send_it) quiet = 1'b0;
        end
        checkOutput("idle_after_drop", 32'(quiet), 1);

        // Reset in the GAP of the 5th load, then restart from a clean frame.
        applyStimulus(1'b1, 8'h55, 2'd0, 1'b1, 1'b1);
        loads = 0;
        for (int i = 0; i < BUDGET && loads < 5; i++) begin
            @(negedge clock);
            if (load_color) loads++;
        end
        checkOutput("fifth_load_seen", 32'(loads), 5);
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clock);
            if (load_color) begin
                seen = 1'b1;
                checkOutput("restart_pixel", 32'(pixel_index), 0);
                checkOutput("restart_color", 32'(color_index), 0);
                checkOutput("restart_level", 32'(color_level), 32'h55);
                checkOutput("restart_position", 32'(position), 0);
            end
        end
        checkOutput("restart_load_seen", 32'(seen), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
